instr_fetch_queue: RTL and testbench

- Fetch front-end that sits between the program-counter stage and instruction memory.
- Issues sequential word-read requests to instruction memory and buffers the returned instructions, with their PCs, in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (taken branch or jump target), which flushes buffered instructions and discards in-flight responses.

---
 rtl/instr_fetch_queue_if.sv | 53 +++++
 rtl/instr_fetch_queue.sv | 111 +++++++++++
 tb/tb_instr_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// ============================================================================
// Module      : instr_fetch_queue_if
// Description : Redirect, instruction-memory and decode handshake bundle
//               for the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Fetch unit side
  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // Branch unit, instruction memory and decode side
  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module      : instr_fetch_queue
// Description : Sequential instruction fetcher with credit-limited request
//               issue, in-order response FIFO and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  instr_fetch_queue_if.master bus
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_sum_w = c_cnt_w + 1;

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_rsp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [31:0]        r_instr_mem [DEPTH];
  logic [31:0]        r_pc_mem    [DEPTH];

  logic               w_credit_ok;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_rsp_take;
  logic               w_rsp_drop;
  logic               w_push;
  logic               w_pop;
  logic [c_cnt_w-1:0] w_outstanding_nxt;
  logic [31:0]        w_redirect_pc;
  logic               w_unused_pc_lsb;

  // Slots are reserved at request time, so a live response always finds room.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_sum_w'(DEPTH);
  assign w_req_valid = !rst && !bus.redirect_valid && w_credit_ok;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  assign w_rsp_take  = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop  = w_rsp_take && (r_drop_cnt != '0);
  assign w_push      = w_rsp_take && !w_rsp_drop && !bus.redirect_valid;
  assign w_pop       = (r_count != '0) && bus.out_ready;

  assign w_outstanding_nxt = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_take);

  assign w_redirect_pc   = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.out_valid      = (r_count != '0);
  assign bus.out_instr      = r_instr_mem[r_rptr];
  assign bus.out_pc         = r_pc_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_outstanding_nxt;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wptr   <= r_wptr + c_ptr_w'(1);
        end
        if (w_rsp_drop) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_ptr_w'(1);
        end
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= bus.imem_rsp_data;
      r_pc_mem[r_wptr]    <= r_rsp_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed self-checking bench for instr_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  always #5 clk = ~clk;

  instr_fetch_queue_if ifa ();
  instr_fetch_queue_if ifb ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  int          errors = 0;
  int          checks = 0;
  bit          auto_rsp;
  int          req_cnt;
  int          pop_cnt;
  logic [31:0] req_log       [16];
  logic [31:0] pop_pc_log    [16];
  logic [31:0] pop_instr_log [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_cnt = 0;
    pop_cnt = 0;
  endtask

  // One clock of DUT A: log request/pop handshakes, then model a memory
  // that answers each accepted request one cycle later with addr ^ C0DE_0000.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    #1;
    f = ifa.imem_req_valid && ifa.imem_req_ready;
    a = ifa.imem_addr;
    if (f) begin
      if (req_cnt < 16) req_log[req_cnt] = a;
      req_cnt++;
    end
    if (ifa.out_valid && ifa.out_ready) begin
      if (pop_cnt < 16) begin
        pop_pc_log[pop_cnt]    = ifa.out_pc;
        pop_instr_log[pop_cnt] = ifa.out_instr;
      end
      pop_cnt++;
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      ifa.imem_rsp_valid = f;
      ifa.imem_rsp_data  = f ? (a ^ 32'hC0DE_0000) : 32'h0;
    end
    #1;
  endtask

  task automatic cyc();
    #1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    rst_b = 1'b1;
    auto_rsp = 1'b1;
    clear_logs();
    ifa.redirect_valid = 1'b0; ifa.redirect_pc = 32'h0;
    ifa.imem_req_ready = 1'b0; ifa.imem_rsp_valid = 1'b0;
    ifa.imem_rsp_data  = 32'h0; ifa.out_ready = 1'b0;
    ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'h0;
    ifb.imem_req_ready = 1'b0; ifb.imem_rsp_valid = 1'b0;
    ifb.imem_rsp_data  = 32'h0; ifb.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", ifa.imem_req_valid, 32'h0);
    chk("rst_out_valid", ifa.out_valid, 32'h0);
    chk("rst_addr", ifa.imem_addr, 32'h0);

    // Free-running stream, one-cycle memory, decode always ready
    clear_logs();
    rst = 1'b0; ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b1;
    tick();
    chk("run_ov_first", ifa.out_valid, 32'h0);
    chk("run_addr_second", ifa.imem_addr, 32'h4);
    tick();
    chk("run_ov_second", ifa.out_valid, 32'h1);
    chk("run_pc0", ifa.out_pc, 32'h0);
    chk("run_instr0", ifa.out_instr, 32'hC0DE_0000);
    tick();
    chk("run_pc4", ifa.out_pc, 32'h4);
    chk("run_instr4", ifa.out_instr, 32'hC0DE_0004);
    tick();
    chk("run_pc8", ifa.out_pc, 32'h8);
    chk("run_req3", req_log[3], 32'hC);

    // Decode stalled: credit limit caps issue at DEPTH requests
    rst = 1'b1;
    tick();
    rst = 1'b0; ifa.out_ready = 1'b0;
    clear_logs();
    repeat (8) tick();
    chk("full_req_cnt", req_cnt, 32'd4);
    chk("full_req_valid", ifa.imem_req_valid, 32'h0);
    chk("full_out_valid", ifa.out_valid, 32'h1);
    chk("full_head_pc", ifa.out_pc, 32'h0);
    ifa.out_ready = 1'b1;
    clear_logs();
    repeat (6) tick();
    chk("drain_pc0", pop_pc_log[0], 32'h0);
    chk("drain_pc1", pop_pc_log[1], 32'h4);
    chk("drain_pc2", pop_pc_log[2], 32'h8);
    chk("drain_pc3", pop_pc_log[3], 32'hC);
    chk("drain_instr3", pop_instr_log[3], 32'hC0DE_000C);
    chk("drain_pc4", pop_pc_log[4], 32'h10);
    chk("resume_addr", req_log[0], 32'h10);

    // Memory not ready: address held, no skip or duplicate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    tick();
    tick();
    chk("stall_addr_pre", ifa.imem_addr, 32'h8);
    ifa.imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_addr_hold", ifa.imem_addr, 32'h8);
      chk("stall_valid_hold", ifa.imem_req_valid, 32'h1);
    end
    ifa.imem_req_ready = 1'b1;
    tick();
    tick();
    chk("stall_req_cnt", req_cnt, 32'd4);
    chk("stall_req2", req_log[2], 32'h8);
    chk("stall_req3", req_log[3], 32'hC);

    // Redirect with two requests in flight
    rst = 1'b1; auto_rsp = 1'b0; ifa.imem_rsp_valid = 1'b0;
    tick();
    rst = 1'b0;
    clear_logs();
    tick();
    tick();
    ifa.imem_req_ready = 1'b0;
    chk("redir_inflight", req_cnt, 32'd2);
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_no_req", ifa.imem_req_valid, 32'h0);
    tick();
    ifa.redirect_valid = 1'b0;
    chk("redir_ov", ifa.out_valid, 32'h0);
    chk("redir_addr", ifa.imem_addr, 32'h100);
    ifa.imem_rsp_valid = 1'b1; ifa.imem_rsp_data = 32'hDEAD_0000;
    tick();
    ifa.imem_rsp_data = 32'hDEAD_0004;
    tick();
    ifa.imem_rsp_valid = 1'b0;
    chk("redir_dropped", ifa.out_valid, 32'h0);
    auto_rsp = 1'b1; ifa.imem_req_ready = 1'b1;
    clear_logs();
    tick();
    tick();
    chk("redir_first_req", req_log[0], 32'h100);
    chk("redir_ov_target", ifa.out_valid, 32'h1);
    chk("redir_pc_target", ifa.out_pc, 32'h100);
    chk("redir_instr_target", ifa.out_instr, 32'hC0DE_0100);

    // Redirect colliding with a response and a pop, FIFO non-empty
    rst = 1'b1; auto_rsp = 1'b0; ifa.imem_rsp_valid = 1'b0;
    tick();
    rst = 1'b0; ifa.out_ready = 1'b0;
    tick();
    ifa.imem_rsp_valid = 1'b1; ifa.imem_rsp_data = 32'hAAAA_0000;
    tick();
    ifa.imem_rsp_data = 32'hBBBB_0004;
    tick();
    ifa.imem_rsp_valid = 1'b0;
    tick();
    ifa.imem_req_ready = 1'b0;
    chk("coll_head_pc", ifa.out_pc, 32'h0);
    chk("coll_head_instr", ifa.out_instr, 32'hAAAA_0000);
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0200;
    ifa.imem_rsp_valid = 1'b1; ifa.imem_rsp_data = 32'hCCCC_0008;
    ifa.out_ready = 1'b1;
    tick();
    ifa.redirect_valid = 1'b0; ifa.imem_rsp_valid = 1'b0;
    chk("coll_ov_flushed", ifa.out_valid, 32'h0);
    chk("coll_addr", ifa.imem_addr, 32'h200);
    ifa.imem_rsp_valid = 1'b1; ifa.imem_rsp_data = 32'hDDDD_000C;
    tick();
    ifa.imem_rsp_valid = 1'b0;
    chk("coll_stale_dropped", ifa.out_valid, 32'h0);
    auto_rsp = 1'b1; ifa.imem_req_ready = 1'b1;
    tick();
    tick();
    chk("coll_ov_target", ifa.out_valid, 32'h1);
    chk("coll_pc_target", ifa.out_pc, 32'h200);
    chk("coll_instr_target", ifa.out_instr, 32'hC0DE_0200);

    // Back-to-back redirects: the last one wins
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0300;
    tick();
    ifa.redirect_pc = 32'h0000_0404;
    tick();
    ifa.redirect_valid = 1'b0;
    chk("b2b_addr", ifa.imem_addr, 32'h404);
    chk("b2b_ov", ifa.out_valid, 32'h0);
    tick();
    tick();
    chk("b2b_pc", ifa.out_pc, 32'h404);
    chk("b2b_instr", ifa.out_instr, 32'hC0DE_0404);

    // DUT B: address wrap from RESET_PC and mid-stream reset
    cyc();
    chk("b_rst_addr", ifb.imem_addr, 32'hFFFF_FFF8);
    chk("b_rst_req_valid", ifb.imem_req_valid, 32'h0);
    rst_b = 1'b0; ifb.imem_req_ready = 1'b1;
    #1;
    chk("b_req_valid", ifb.imem_req_valid, 32'h1);
    cyc();
    chk("b_addr_fc", ifb.imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("b_addr_wrap", ifb.imem_addr, 32'h0);
    ifb.imem_req_ready = 1'b0;
    rst_b = 1'b1;
    cyc();
    rst_b = 1'b0;
    chk("b_restart_addr", ifb.imem_addr, 32'hFFFF_FFF8);
    chk("b_restart_ov", ifb.out_valid, 32'h0);
    ifb.imem_rsp_valid = 1'b1; ifb.imem_rsp_data = 32'h1111_1111;
    cyc();
    cyc();
    ifb.imem_rsp_valid = 1'b0;
    chk("b_stale_ignored", ifb.out_valid, 32'h0);
    ifb.imem_req_ready = 1'b1;
    cyc();
    ifb.imem_req_ready = 1'b0;
    ifb.imem_rsp_valid = 1'b1; ifb.imem_rsp_data = 32'h2222_2222;
    cyc();
    ifb.imem_rsp_valid = 1'b0;
    chk("b_ov", ifb.out_valid, 32'h1);
    chk("b_pc", ifb.out_pc, 32'hFFFF_FFF8);
    chk("b_instr", ifb.out_instr, 32'h2222_2222);
    ifb.imem_req_ready = 1'b1;
    cyc();
    cyc();
    ifb.imem_req_ready = 1'b0;
    ifb.imem_rsp_valid = 1'b1; ifb.imem_rsp_data = 32'h3333_3333;
    cyc();
    ifb.imem_rsp_data = 32'h4444_4444;
    cyc();
    ifb.imem_rsp_valid = 1'b0;
    ifb.out_ready = 1'b1;
    cyc();
    chk("b_pc_fc", ifb.out_pc, 32'hFFFF_FFFC);
    chk("b_instr_fc", ifb.out_instr, 32'h3333_3333);
    cyc();
    chk("b_pc_wrap", ifb.out_pc, 32'h0);
    chk("b_instr_wrap", ifb.out_instr, 32'h4444_4444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
